// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter for the ALU result, using shift-and-add-3 (one bit per clock).
// Presents four BCD digits, a sign flag and a leading-zero blanking mask to the 7-segment stage.
module result_bcd_converter #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] value,
    input  logic         is_signed,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd,
    output logic         neg,
    output logic [3:0]   digit_en
);

    localparam logic [3:0] CNT_LAST = 4'(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state;
    state_t       state_nxt;
    logic         start_q;
    logic         start_rise;
    logic [15:0]  scratch;
    logic [15:0]  scratch_adj;
    logic [3:0]   cnt;
    logic [W-1:0] mag;
    logic         sign_q;
    logic         last_shift;

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

    function automatic logic [3:0] blank_mask(input logic [15:0] digits);
        logic [3:0] m;
        m[3] = (digits[15:12] != 4'd0);
        m[2] = m[3] | (digits[11:8] != 4'd0);
        m[1] = m[2] | (digits[7:4] != 4'd0);
        m[0] = 1'b1;
        return m;
    endfunction

    assign start_rise  = start & ~start_q;
    assign busy        = (state != IDLE);
    assign last_shift  = (state == SHIFT) && (cnt == CNT_LAST);
    assign scratch_adj = {add3(scratch[15:12]), add3(scratch[11:8]),
                          add3(scratch[7:4]),   add3(scratch[3:0])};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_rise) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and output registers; cnt reaching W means all bits have been shifted in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q  <= 1'b0;
            scratch  <= 16'd0;
            cnt      <= 4'd0;
            bcd      <= 16'd0;
            neg      <= 1'b0;
            digit_en <= 4'b0001;
            done     <= 1'b0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            if (state == IDLE && start_rise) begin
                scratch <= 16'd0;
                cnt     <= 4'd0;
            end else if (last_shift) begin
                bcd      <= scratch;
                neg      <= sign_q;
                digit_en <= blank_mask(scratch);
                done     <= 1'b1;
            end else if (state == SHIFT) begin
                scratch <= {scratch_adj[14:0], mag[W-1]};
                cnt     <= cnt + 4'd1;
            end
        end
    end

    // Captured operand: magnitude shifts out MSB first, sign is held for the whole conversion
    always_ff @(posedge clk) begin
        if (state == IDLE && start_rise) begin
            sign_q <= is_signed & value[W-1];
            mag    <= (is_signed && value[W-1]) ? -value : value;
        end else if (state == SHIFT && !last_shift) begin
            mag <= {mag[W-2:0], 1'b0};
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: directed conversions, start-edge handling and mid-conversion reset.
module tb_result_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] value = 12'd0;
    logic        is_signed = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        neg;
    logic [3:0]  digit_en;

    typedef struct packed {
        logic [15:0] bcd;
        logic        neg;
        logic [3:0]  en;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;

    result_bcd_converter #(.W(12)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .is_signed(is_signed),
        .busy(busy), .done(done), .bcd(bcd), .neg(neg), .digit_en(digit_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            exp_t e;
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("bcd", {16'd0, bcd}, {16'd0, e.bcd});
                check("neg", {31'd0, neg}, {31'd0, e.neg});
                check("digit_en", {28'd0, digit_en}, {28'd0, e.en});
            end
        end
    end

    task automatic run(input logic [11:0] v, input logic s,
                       input logic [15:0] eb, input logic en, input logic [3:0] ee);
        int k;
        value = v;
        is_signed = s;
        exp_q.push_back('{bcd: eb, neg: en, en: ee});
        start = 1'b1;
        @(posedge clk); #1;
        check("busy_after_capture", {31'd0, busy}, 32'd1);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                k = i;
                break;
            end
            if (!busy) check("busy_held", 32'd0, 32'd1);
        end
        if (k == 0) check("done_timeout", 32'd0, 32'd1);
        else        check("done_latency", k, 32'd13);
        @(posedge clk); #1;
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("done_fall", {31'd0, done}, 32'd0);
        check("bcd_hold", {16'd0, bcd}, {16'd0, eb});
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_bcd", {16'd0, bcd}, 32'd0);
        check("rst_neg", {31'd0, neg}, 32'd0);
        check("rst_digit_en", {28'd0, digit_en}, 32'd1);
        #10 rst = 1'b1;
        @(posedge clk); #1;

        run(12'hFE5, 1'b1, 16'h0027, 1'b1, 4'b0011);
        run(12'hFFF, 1'b0, 16'h4095, 1'b0, 4'b1111);
        run(12'h800, 1'b1, 16'h2048, 1'b1, 4'b1111);
        run(12'h000, 1'b0, 16'h0000, 1'b0, 4'b0001);
        run(12'd100, 1'b0, 16'h0100, 1'b0, 4'b0111);
        run(12'h7FF, 1'b1, 16'h2047, 1'b0, 4'b1111);
        run(12'hFFF, 1'b1, 16'h0001, 1'b1, 4'b0001);

        // start held high for 100 cycles: exactly one conversion
        d0 = done_count;
        value = 12'd321;
        is_signed = 1'b0;
        exp_q.push_back('{bcd: 16'h0321, neg: 1'b0, en: 4'b0111});
        start = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("held_start_dones", done_count - d0, 32'd1);
        start = 1'b0;
        @(posedge clk); #1;

        // value change and start re-toggle during SHIFT are both ignored
        d0 = done_count;
        value = 12'd1234;
        exp_q.push_back('{bcd: 16'h1234, neg: 1'b0, en: 4'b1111});
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1 value = 12'd999;
        repeat (2) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("toggle_start_dones", done_count - d0, 32'd1);
        start = 1'b0;
        @(posedge clk); #1;

        // reset asserted just after E6 aborts the conversion silently
        d0 = done_count;
        value = 12'd777;
        start = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_bcd", {16'd0, bcd}, 32'd0);
        check("abort_digit_en", {28'd0, digit_en}, 32'd1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", done_count - d0, 32'd0);
        check("abort_idle", {31'd0, busy}, 32'd0);
        run(12'd9, 1'b0, 16'h0009, 1'b0, 4'b0001);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/result_bcd_converter.md
# result_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the ALU. It captures the ALU's 12-bit `result` on a `start` rising edge and converts its magnitude to four BCD digits with the shift-and-add-3 (double-dabble) method, one bit per clock. It then presents the digits, a sign flag and a leading-zero blanking mask to the seven-segment decode stage.

## Interface
- `W`, 12: input width; fixed for this block, with 4 BCD digits covering 0..4095.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level input from the board; only its rising edge launches a conversion.
- `value`  in  12  binary input, connected to the ALU `result`.
- `is_signed`  in  1  1 = interpret `value` as two's complement; 0 = unsigned.
- `busy`  out  1  high while a conversion is in progress or completing.
- `done`  out  1  single-cycle pulse when new outputs become valid.
- `bcd`  out  16  four BCD digits; `[3:0]` is ones, `[15:12]` is thousands.
- `neg`  out  1  sign of the captured value; 1 only when `is_signed` and `value[11]`.
- `digit_en`  out  4  leading-zero blanking mask; bit i = 1 means digit i is displayed.

## Operation
- **Edge detect:** `start_q` registers `start` every cycle. `start_rise = start & ~start_q`.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - On `start_rise`, capture `value` and `is_signed`.
  - The magnitude `mag` is `-value` (12-bit) if signed and `value[11]`; otherwise it is `value`. -2048 yields `mag` = 2048, which fits.
  - Latch the sign internally.
  - Clear the 16-bit scratch BCD register, set the bit counter to 0, go to SHIFT.
- **SHIFT (12 cycles):**
  - Each cycle, every scratch nibble ≥ 5 gets +3.
  - Then shift {scratch, mag} left by 1.
  - Increment the counter. After the 12th shift, go to DONE.
- **DONE (1 cycle):**
  - Write the final scratch value to `bcd`, the latched sign to `neg`, and the computed mask to `digit_en`.
  - Assert `done`, then return to IDLE.
- **`digit_en`:**
  - Bit 0 is always 1.
  - Bit i (i > 0) is 1 iff any digit at position ≥ i is nonzero.
- **Output persistence:** `bcd`, `neg` and `digit_en` hold their last values until the next DONE. They never show intermediate scratch values.
- **`busy`:** `busy` = (state != IDLE).
- **Start rules:**
  - `start_rise` while busy is ignored; it is not queued.
  - A `start` held high launches exactly one conversion.
  - A new conversion requires `start` to go low then high again, and that rise must occur while in IDLE.
- **`value` changes:** changes to `value` after capture have no effect on the conversion in progress.
- **Reset:** asynchronous `rst` low forces IDLE and clears `bcd`, scratch, counter, `start_q`, `neg`, `busy` and `done` to 0, and sets `digit_en` to 4'b0001. This applies at any time, including mid-SHIFT, and aborts the conversion with no `done` pulse.

## Timing
- Let E0 be the clock edge at which `start_rise` is sampled in IDLE.
- `busy` rises after E0.
- SHIFT occupies edges E1..E12.
- Outputs update and `done` = 1 after E13; `done` falls and `busy` falls after E14.
- Latency: 13 cycles from the capture edge to valid outputs.
- Throughput: at most one conversion per 15 cycles, counting the `start` low phase, which requires at least 1 cycle.
- `start_q` is 1 cycle, so a `start` rise is seen on the first edge at which `start` = 1.
- No combinational path from any input to any output.

## Test plan
- **Signed negative:** reset, `is_signed`=1, `value`=12'hFE5 (-27, i.e. 9 × -3), `start` 0→1. Required: `busy` for 14 cycles, one `done` pulse 13 cycles after capture, `bcd`=16'h0027, `neg`=1, `digit_en`=4'b0011.
- **Unsigned max and signed min:**
  - `is_signed`=0, `value`=12'hFFF → `bcd`=16'h4095, `neg`=0, `digit_en`=4'b1111.
  - `is_signed`=1, `value`=12'h800 → `bcd`=16'h2048, `neg`=1.
- **Zero:** `value`=0 → `bcd`=16'h0000, `neg`=0, `digit_en`=4'b0001. Also `value`=12'd100 unsigned → `bcd`=16'h0100, `digit_en`=4'b0111.
- **Start handling:**
  - Hold `start` high for 100 cycles → exactly one `done`.
  - Toggle `start` low/high during SHIFT → ignored, no second `done`.
  - Change `value` mid-SHIFT → result still reflects the captured value.
- **Reset mid-operation:** assert `rst` low at E6 of a conversion. Required: immediately `busy`=0, `bcd`=0, `digit_en`=4'b0001, no `done`. After release, a new `start` rise converts 12'd9 → `bcd`=16'h0009.
